// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Segment codes are active-low, bit7 = dp, bits6..0 = g..a.
package seg_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_CONV
   } conv_state_e;

   localparam int NUM_DIGITS = 6;

   localparam int DIG_SEC_U = 0;
   localparam int DIG_SEC_T = 1;
   localparam int DIG_MIN_U = 2;
   localparam int DIG_MIN_T = 3;
   localparam int DIG_HR_U  = 4;
   localparam int DIG_HR_T  = 5;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_MINUS = 8'hBF;
   localparam logic [7:0] SEG_OFF   = 8'hFF;
   localparam logic [5:0] SEL_OFF   = 6'h3F;

   // Display digit value reserved for "field out of range".
   localparam logic [3:0] DIG_MINUS  = 4'hA;
   localparam logic [3:0] CONV_STEPS = 4'd8;

   function automatic logic [7:0] seg_code(input logic [3:0] dig);
      case (dig)
         4'd0:      seg_code = SEG_0;
         4'd1:      seg_code = SEG_1;
         4'd2:      seg_code = SEG_2;
         4'd3:      seg_code = SEG_3;
         4'd4:      seg_code = SEG_4;
         4'd5:      seg_code = SEG_5;
         4'd6:      seg_code = SEG_6;
         4'd7:      seg_code = SEG_7;
         4'd8:      seg_code = SEG_8;
         4'd9:      seg_code = SEG_9;
         DIG_MINUS: seg_code = SEG_MINUS;
         default:   seg_code = SEG_OFF;
      endcase
   endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Iterative 8-bit binary to BCD (shift-add-3): load_i captures bin_i, each step_i shifts one bit, result valid after 8 steps.
// No backpressure; the hundreds digit is kept only to flag values above 99.
module bin_to_bcd (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic       step_i,
   input  logic [7:0] bin_i,
   output logic [3:0] tens_o,
   output logic [3:0] units_o,
   output logic       ovf_o
);

   logic [7:0]  bin_q, bin_d;
   logic [11:0] bcd_q, bcd_d, bcd_adj;

   always_comb begin
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      bcd_adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end
      end
      if (load_i) begin
         bin_d = bin_i;
         bcd_d = '0;
      end else if (step_i) begin
         {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q <= '0;
         bcd_q <= '0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
      end
   end

   assign tens_o  = bcd_q[7:4];
   assign units_o = bcd_q[3:0];
   assign ovf_o   = (bcd_q[11:8] != 4'd0);

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit HH:MM:SS 7-segment scan driver with anti-ghost blanking; sel/seg registered one cycle after registered sel_gen.
// No backpressure: digit timing is set entirely by sel_gen, display digits refresh 9 edges after each frame start.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter logic [15:0] BLANK_CYC = 16'd49,
   parameter logic [5:0]  DP_MASK   = 6'b010_100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] hours,
   input  logic [7:0] minutes,
   input  logic [7:0] seconds,
   input  logic [5:0] sel_gen,
   output logic [5:0] sel,
   output logic [7:0] seg
);

   logic [5:0]  sel_gen_q;
   logic [15:0] blank_cnt_q, blank_cnt_d;
   logic [5:0]  sel_q, sel_d;
   logic [7:0]  seg_q, seg_d;
   conv_state_e state_q;
   logic [3:0]  step_cnt_q;
   logic [3:0]  disp_q [NUM_DIGITS];

   logic        digit_chg, frame_start, conv_step;
   logic        sel_onehot, blank, cur_dp;
   logic [3:0]  cur_dig;
   logic [7:0]  cur_code;
   logic [3:0]  hr_t, hr_u, mn_t, mn_u, sc_t, sc_u;
   logic        hr_ovf, mn_ovf, sc_ovf;

   assign digit_chg   = (sel_gen != sel_gen_q);
   assign frame_start = digit_chg && (sel_gen == 6'b000_001);
   assign conv_step   = (state_q == ST_CONV) && (step_cnt_q != CONV_STEPS);

   bin_to_bcd u_bcd_hr (
      .clk    (clk),
      .rst    (rst),
      .load_i (frame_start),
      .step_i (conv_step),
      .bin_i  (hours),
      .tens_o (hr_t),
      .units_o(hr_u),
      .ovf_o  (hr_ovf)
   );

   bin_to_bcd u_bcd_mn (
      .clk    (clk),
      .rst    (rst),
      .load_i (frame_start),
      .step_i (conv_step),
      .bin_i  (minutes),
      .tens_o (mn_t),
      .units_o(mn_u),
      .ovf_o  (mn_ovf)
   );

   bin_to_bcd u_bcd_sc (
      .clk    (clk),
      .rst    (rst),
      .load_i (frame_start),
      .step_i (conv_step),
      .bin_i  (seconds),
      .tens_o (sc_t),
      .units_o(sc_u),
      .ovf_o  (sc_ovf)
   );

   // A new frame start always wins, so a restarted conversion never publishes stale digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         step_cnt_q <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            disp_q[i] <= '0;
         end
      end else if (frame_start) begin
         state_q    <= ST_CONV;
         step_cnt_q <= '0;
      end else if (state_q == ST_CONV) begin
         if (step_cnt_q == CONV_STEPS) begin
            state_q           <= ST_IDLE;
            disp_q[DIG_HR_T]  <= hr_ovf ? DIG_MINUS : hr_t;
            disp_q[DIG_HR_U]  <= hr_ovf ? DIG_MINUS : hr_u;
            disp_q[DIG_MIN_T] <= mn_ovf ? DIG_MINUS : mn_t;
            disp_q[DIG_MIN_U] <= mn_ovf ? DIG_MINUS : mn_u;
            disp_q[DIG_SEC_T] <= sc_ovf ? DIG_MINUS : sc_t;
            disp_q[DIG_SEC_U] <= sc_ovf ? DIG_MINUS : sc_u;
         end else begin
            step_cnt_q <= step_cnt_q + 4'd1;
         end
      end
   end

   // Blanking covers the change edge itself plus BLANK_CYC counted cycles.
   always_comb begin
      cur_dig = '0;
      cur_dp  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_gen_q[i]) begin
            cur_dig = disp_q[i];
            cur_dp  = DP_MASK[i];
         end
      end
      cur_code    = seg_code(cur_dig);
      sel_onehot  = (sel_gen_q != 6'd0) && ((sel_gen_q & (sel_gen_q - 6'd1)) == 6'd0);
      blank       = digit_chg || (blank_cnt_q != 16'd0) || !sel_onehot;
      sel_d       = blank ? SEL_OFF : ~sel_gen_q;
      seg_d       = blank ? SEG_OFF : {cur_code[7] & ~cur_dp, cur_code[6:0]};
      blank_cnt_d = digit_chg ? BLANK_CYC :
                    ((blank_cnt_q != 16'd0) ? blank_cnt_q - 16'd1 : blank_cnt_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_gen_q   <= '0;
         blank_cnt_q <= BLANK_CYC;
         sel_q       <= SEL_OFF;
         seg_q       <= SEG_OFF;
      end else begin
         sel_gen_q   <= sel_gen;
         blank_cnt_q <= blank_cnt_d;
         sel_q       <= sel_d;
         seg_q       <= seg_d;
      end
   end

   assign sel = sel_q;
   assign seg = seg_q;

endmodule
